// File: rtl/cmac_pkg.sv
// Shared definitions for the CMAC receive path: default beat widths, the
// beat layout used in the packet buffer, and the write-side FSM states.
package cmac_pkg;

  localparam int CMAC_DATA_W = 512;
  localparam int CMAC_KEEP_W = CMAC_DATA_W / 8;

  // One buffered beat at default widths. Parameterised blocks pack their
  // own beats in this same {tdata, tkeep, tlast} order.
  typedef struct packed {
    logic [CMAC_DATA_W-1:0] tdata;
    logic [CMAC_KEEP_W-1:0] tkeep;
    logic                   tlast;
  } axis_beat_t;

  typedef enum logic [1:0] {
    WR_SOP  = 2'd0,
    WR_BODY = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_ram_1r1w.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Contents are not reset; read data holds while rd_en is low.
module sync_ram_1r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share one clock.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cmac_rx_pkt_fifo.sv
// Store-and-forward packet FIFO between CMAC RX and the MAC-swap hairpin.
// Whole packets are committed on their last beat; errored or overflowing
// packets are rewound and never reach the output.
// Optional feature: define CMAC_RX_FIFO_STATS_EN to build the saturating
// statistics counters; otherwise the counter ports are tied to zero.
//
// Write FSM:
//   state   | meaning
//   WR_SOP  | waiting for the first beat of a packet
//   WR_BODY | packet in progress, beats being written past wr_commit
//   WR_DROP | packet overflowed, discarding beats up to its tlast
//
// rd_ptr counts beats handed downstream; fetch_ptr runs up to two beats
// ahead of it into the prefetch skid. Fullness is measured against rd_ptr so
// that RAM slots are only reused once their beat has left the block.
module cmac_rx_pkt_fifo
  import cmac_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = CMAC_DATA_W,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              cmac_clk,
  input  logic              rst,
  input  logic              s_axis_cmac_tvalid,
  input  logic [DATA_W-1:0] s_axis_cmac_tdata,
  input  logic [KEEP_W-1:0] s_axis_cmac_tkeep,
  input  logic              s_axis_cmac_tlast,
  input  logic              s_axis_cmac_tuser_err,
  output logic              s_axis_cmac_tready,
  output logic              m_axis_hp_tvalid,
  output logic [DATA_W-1:0] m_axis_hp_tdata,
  output logic [KEEP_W-1:0] m_axis_hp_tkeep,
  output logic              m_axis_hp_tlast,
  output logic              m_axis_hp_tuser_err,
  input  logic              m_axis_hp_tready,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       drop_err_cnt,
  output logic [31:0]       drop_ovf_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int BEAT_W = DATA_W + KEEP_W + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  wr_state_e   wr_state, wr_state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] wr_commit, wr_commit_nxt;
  logic [PW-1:0] rd_ptr, fetch_ptr;
  logic          full;
  logic          ram_we, ram_re;
  logic          inc_pkt, inc_err, inc_ovf;

  logic [BEAT_W-1:0] beat_in, ram_q, out_beat, skid_beat;
  logic              ram_vld, skid_vld, out_vld;
  logic              pop, out_load;
  logic [1:0]        held, held_after;

  assign s_axis_cmac_tready  = 1'b1;
  assign m_axis_hp_tuser_err = 1'b0;

  assign beat_in = {s_axis_cmac_tdata, s_axis_cmac_tkeep, s_axis_cmac_tlast};
  assign full    = (wr_ptr - rd_ptr) == PW'(DEPTH);

  // Write FSM state and pointer registers.
  always_ff @(posedge cmac_clk) begin
    if (rst) begin
      wr_state  <= WR_SOP;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      wr_state  <= wr_state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
    end
  end

  // Next-state, write enable and commit/rewind decisions per input beat.
  always_comb begin
    wr_state_nxt  = wr_state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    ram_we        = 1'b0;
    inc_pkt       = 1'b0;
    inc_err       = 1'b0;
    inc_ovf       = 1'b0;
    if (s_axis_cmac_tvalid) begin
      unique case (wr_state)
        WR_SOP: begin
          if (full) begin
            inc_ovf = 1'b1;
            if (!s_axis_cmac_tlast) wr_state_nxt = WR_DROP;
          end else begin
            ram_we = 1'b1;
            if (s_axis_cmac_tlast) begin
              if (s_axis_cmac_tuser_err) begin
                inc_err = 1'b1;
              end else begin
                wr_ptr_nxt    = wr_ptr + PTR_ONE;
                wr_commit_nxt = wr_ptr + PTR_ONE;
                inc_pkt       = 1'b1;
              end
            end else begin
              wr_ptr_nxt   = wr_ptr + PTR_ONE;
              wr_state_nxt = WR_BODY;
            end
          end
        end
        WR_BODY: begin
          if (full) begin
            wr_ptr_nxt   = wr_commit;
            inc_ovf      = 1'b1;
            wr_state_nxt = s_axis_cmac_tlast ? WR_SOP : WR_DROP;
          end else begin
            ram_we = 1'b1;
            if (s_axis_cmac_tlast) begin
              if (s_axis_cmac_tuser_err) begin
                wr_ptr_nxt = wr_commit;
                inc_err    = 1'b1;
              end else begin
                wr_ptr_nxt    = wr_ptr + PTR_ONE;
                wr_commit_nxt = wr_ptr + PTR_ONE;
                inc_pkt       = 1'b1;
              end
              wr_state_nxt = WR_SOP;
            end else begin
              wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
          end
        end
        WR_DROP: begin
          if (s_axis_cmac_tlast) wr_state_nxt = WR_SOP;
        end
        default: wr_state_nxt = WR_SOP;
      endcase
    end
  end

  sync_ram_1r1w #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (cmac_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (beat_in),
    .rd_en   (ram_re),
    .rd_addr (fetch_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  // Beats already pulled out of the RAM must fit in out + skid, so a fetch
  // is issued only while fewer than two remain held after this cycle's pop.
  assign pop        = out_vld & m_axis_hp_tready;
  assign out_load   = ~out_vld | m_axis_hp_tready;
  assign held       = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, ram_vld};
  assign held_after = held - {1'b0, pop};
  assign ram_re     = (fetch_ptr != wr_commit) && (held_after < 2'd2);

  // Fetch and release pointers plus the RAM read-data valid flag.
  always_ff @(posedge cmac_clk) begin
    if (rst) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
    end else begin
      if (ram_re) fetch_ptr <= fetch_ptr + PTR_ONE;
      if (pop)    rd_ptr    <= rd_ptr + PTR_ONE;
      ram_vld <= ram_re;
    end
  end

  // Output register fed from the skid first, then straight from the RAM.
  always_ff @(posedge cmac_clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_beat  <= '0;
      skid_vld  <= 1'b0;
      skid_beat <= '0;
    end else if (out_load) begin
      if (skid_vld) begin
        out_beat <= skid_beat;
        out_vld  <= 1'b1;
        skid_vld <= ram_vld;
        if (ram_vld) skid_beat <= ram_q;
      end else if (ram_vld) begin
        out_beat <= ram_q;
        out_vld  <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (ram_vld) begin
      skid_beat <= ram_q;
      skid_vld  <= 1'b1;
    end
  end

  assign m_axis_hp_tvalid = out_vld;
  assign m_axis_hp_tdata  = out_beat[BEAT_W-1 -: DATA_W];
  assign m_axis_hp_tkeep  = out_beat[KEEP_W:1];
  assign m_axis_hp_tlast  = out_beat[0];

`ifdef CMAC_RX_FIFO_STATS_EN
  // Saturating per-packet statistics.
  always_ff @(posedge cmac_clk) begin
    if (rst) begin
      pkt_cnt      <= '0;
      drop_err_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else begin
      if (inc_pkt) pkt_cnt      <= sat_inc(pkt_cnt);
      if (inc_err) drop_err_cnt <= sat_inc(drop_err_cnt);
      if (inc_ovf) drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{inc_pkt, inc_err, inc_ovf};
  assign pkt_cnt      = '0;
  assign drop_err_cnt = '0;
  assign drop_ovf_cnt = '0;
`endif

endmodule
